// File: rtl/uart_rx_massiv_collector.sv
// Gathers consecutive UART RX packs into one pack-array frame, closed on full or idle gap,
// and holds the frame until the consumer acknowledges it.
module uart_rx_massiv_collector #(
    parameter int unsigned UART_BAUD_RATE           = 9600,
    parameter int unsigned CLOCK_FREQUENCY          = 50000000,
    parameter int unsigned NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int unsigned RX_MASSIV_DEEP           = 4,
    parameter int unsigned IDLE_GAP_BITS            = 20,
    parameter int unsigned RX_MASSIV_DEEP_LOG_2     = $clog2(RX_MASSIV_DEEP)
) (
    input  logic                                                 IN_CLOCK,
    input  logic                                                 IN_RESET,
    input  logic                                                 IN_PACK_READY,
    input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0]                  IN_PACK_DATA,
    input  logic                                                 IN_PACK_ERROR,
    input  logic                                                 IN_FRAME_ACK,
    output logic                                                 OUT_FRAME_VALID,
    output logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0]   OUT_FRAME_DATA,
    output logic [RX_MASSIV_DEEP_LOG_2:0]                        OUT_FRAME_NUM_PACKS,
    output logic                                                 OUT_FRAME_ERROR,
    output logic                                                 OUT_FRAME_OVERFLOW,
    output logic                                                 OUT_BUSY
);

    localparam int unsigned N            = NUM_OF_DATA_BITS_IN_PACK;
    localparam int unsigned D            = RX_MASSIV_DEEP;
    localparam int unsigned FW           = N * D;
    localparam int unsigned CW           = RX_MASSIV_DEEP_LOG_2 + 1;
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int unsigned IDLE_T       = CLKS_PER_BIT * IDLE_GAP_BITS;
    localparam int unsigned TW           = (IDLE_T > 1) ? $clog2(IDLE_T) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [FW-1:0]   frame_data;
    logic [CW-1:0]   frame_cnt;
    logic            frame_err;
    logic            frame_ovf;
    logic            start_frame;

    // An ack in the same cycle as a pack lets that pack open the next frame.
    assign start_frame = IN_PACK_READY &&
                         ((state == S_IDLE) || ((state == S_HOLD) && IN_FRAME_ACK));

    always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
        if (IN_RESET) begin
            state      <= S_IDLE;
            timer      <= '0;
            frame_data <= '0;
            frame_cnt  <= '0;
            frame_err  <= 1'b0;
            frame_ovf  <= 1'b0;
        end else if (start_frame) begin
            frame_data <= FW'(IN_PACK_DATA);
            frame_cnt  <= CW'(1);
            frame_err  <= IN_PACK_ERROR;
            frame_ovf  <= 1'b0;
            timer      <= '0;
            state      <= (D == 1) ? S_HOLD : S_COLLECT;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (IN_PACK_READY) begin
                        for (int k = 0; k < int'(D); k++) begin
                            if (frame_cnt == CW'(k)) begin
                                frame_data[k*N +: N] <= IN_PACK_DATA;
                            end
                        end
                        frame_cnt <= frame_cnt + CW'(1);
                        frame_err <= frame_err | IN_PACK_ERROR;
                        timer     <= '0;
                        if (frame_cnt + CW'(1) == CW'(D)) begin
                            state <= S_HOLD;
                        end
                    end else if (timer == TW'(IDLE_T - 1)) begin
                        state <= S_HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (IN_FRAME_ACK) begin
                        frame_ovf <= 1'b0;
                        state     <= S_IDLE;
                    end else if (IN_PACK_READY) begin
                        frame_ovf <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign OUT_FRAME_VALID     = (state == S_HOLD);
    assign OUT_BUSY            = (state == S_COLLECT);
    assign OUT_FRAME_DATA      = frame_data;
    assign OUT_FRAME_NUM_PACKS = frame_cnt;
    assign OUT_FRAME_ERROR     = frame_err;
    assign OUT_FRAME_OVERFLOW  = frame_ovf;

endmodule

// File: tb/tb_uart_rx_massiv_collector.sv
// Scoreboard bench for uart_rx_massiv_collector: stimulus pushes expected frames,
// a negedge monitor pops and compares on each rise of OUT_FRAME_VALID.
module tb_uart_rx_massiv_collector;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        err;
        int          at_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic [7:0]  pdata = '0;
    logic        perr = 1'b0;
    logic        ack = 1'b0;
    logic        valid;
    logic [31:0] fdata;
    logic [2:0]  fcnt;
    logic        ferr;
    logic        fovf;
    logic        busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev_v = 1'b0;
    exp_t exp_q[$];

    uart_rx_massiv_collector #(
        .UART_BAUD_RATE(5000000),
        .CLOCK_FREQUENCY(50000000),
        .NUM_OF_DATA_BITS_IN_PACK(8),
        .RX_MASSIV_DEEP(4),
        .IDLE_GAP_BITS(20)
    ) dut (
        .IN_CLOCK(clk),
        .IN_RESET(rst),
        .IN_PACK_READY(ready),
        .IN_PACK_DATA(pdata),
        .IN_PACK_ERROR(perr),
        .IN_FRAME_ACK(ack),
        .OUT_FRAME_VALID(valid),
        .OUT_FRAME_DATA(fdata),
        .OUT_FRAME_NUM_PACKS(fcnt),
        .OUT_FRAME_ERROR(ferr),
        .OUT_FRAME_OVERFLOW(fovf),
        .OUT_BUSY(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one pack at the current negedge; optionally queue the frame it closes.
    task automatic send_pack(input logic [7:0] d, input logic e, input bit push,
                             input logic [31:0] xd, input logic [2:0] xc, input logic xe,
                             input int lat);
        exp_t x;
        if (push) begin
            x.data = xd; x.cnt = xc; x.err = xe; x.at_edge = cyc + 1 + lat;
            exp_q.push_back(x);
        end
        ready = 1'b1; pdata = d; perr = e;
        @(negedge clk);
        ready = 1'b0; perr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string nm);
        int i = 0;
        while (!valid && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({nm, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack_valid_low", 32'(valid), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_valid"}, 32'(valid), 32'd0);
        check({nm, "_data"},  fdata,      32'd0);
        check({nm, "_count"}, 32'(fcnt),  32'd0);
        check({nm, "_err"},   32'(ferr),  32'd0);
        check({nm, "_ovf"},   32'(fovf),  32'd0);
        check({nm, "_busy"},  32'(busy),  32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_data",  fdata,     e.data);
                check("frame_count", 32'(fcnt), 32'(e.cnt));
                check("frame_err",   32'(ferr), 32'(e.err));
                check("frame_ovf",   32'(fovf), 32'd0);
                check("rise_edge",   32'(cyc),  32'(e.at_edge));
            end
        end
        prev_v = valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Async reset mid-COLLECT with two packs stored
        send_pack(8'h01, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'h02, 1'b0, 1'b0, 0, 0, 0, 0);
        check("pre_reset_count", 32'(fcnt), 32'd2);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        send_pack(8'h3C, 1'b0, 1'b1, 32'h0000003C, 3'd1, 1'b0, 200);
        check("post_reset_data",  fdata,     32'h0000003C);
        check("post_reset_count", 32'(fcnt), 32'd1);
        check("post_reset_busy",  32'(busy), 32'd1);
        wait_valid("post_reset");
        do_ack();

        // Full frame, 100-cycle spacing
        send_pack(8'h11, 1'b0, 1'b0, 0, 0, 0, 0); idle(99);
        send_pack(8'h22, 1'b0, 1'b0, 0, 0, 0, 0); idle(99);
        send_pack(8'h33, 1'b0, 1'b0, 0, 0, 0, 0); idle(99);
        send_pack(8'h44, 1'b0, 1'b1, 32'h44332211, 3'd4, 1'b0, 0);
        wait_valid("full");
        check("full_busy", 32'(busy), 32'd0);
        do_ack();

        // Idle close exactly T after the last pack
        send_pack(8'hA5, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'h5A, 1'b0, 1'b1, 32'h00005AA5, 3'd2, 1'b0, 200);
        wait_valid("idle_close");
        do_ack();

        // Pack at T-1 restarts the timer
        send_pack(8'hA5, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'h5A, 1'b0, 1'b0, 0, 0, 0, 0);
        idle(198);
        send_pack(8'hC3, 1'b0, 1'b1, 32'h00C35AA5, 3'd3, 1'b0, 200);
        check("late_pack_busy", 32'(busy), 32'd1);
        wait_valid("late_pack");
        do_ack();

        // Error flag on the second pack, then a clean frame
        send_pack(8'h10, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'h20, 1'b1, 1'b1, 32'h00002010, 3'd2, 1'b1, 200);
        wait_valid("error");
        do_ack();
        send_pack(8'h30, 1'b0, 1'b1, 32'h00000030, 3'd1, 1'b0, 200);
        wait_valid("after_error");
        do_ack();

        // Consecutive pulses fill a frame, then overflow while held
        send_pack(8'hA1, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'hB2, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'hC3, 1'b0, 1'b0, 0, 0, 0, 0);
        send_pack(8'hD4, 1'b0, 1'b1, 32'hD4C3B2A1, 3'd4, 1'b0, 0);
        idle(3);
        send_pack(8'h77, 1'b0, 1'b0, 0, 0, 0, 0);
        check("ovf_flag",  32'(fovf),  32'd1);
        check("ovf_data",  fdata,      32'hD4C3B2A1);
        check("ovf_count", 32'(fcnt),  32'd4);
        check("ovf_valid", 32'(valid), 32'd1);

        // Ack and pack in the same cycle
        ack = 1'b1;
        send_pack(8'h99, 1'b0, 1'b1, 32'h00000099, 3'd1, 1'b0, 200);
        ack = 1'b0;
        check("race_valid", 32'(valid), 32'd0);
        check("race_ovf",   32'(fovf),  32'd0);
        check("race_data",  fdata,      32'h00000099);
        check("race_count", 32'(fcnt),  32'd1);
        check("race_busy",  32'(busy),  32'd1);
        wait_valid("race");
        do_ack();

        idle(5);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_massiv_collector.md
# uart_rx_massiv_collector

Receive-side frame assembler for the UART pack link. It takes the single-pack output of the UART receiver and gathers consecutive packs into one pack-array frame. A frame closes when the array is full or when the line has been idle for a configurable number of bit periods. The completed frame is then held for the consumer until it is acknowledged. This makes it the synchronous receive counterpart of the array transmitter: a frame sent as N back-to-back packs arrives here as one N-pack frame.

## Interface
- UART_BAUD_RATE, 9600, line bit rate; used only for the idle timeout.
- CLOCK_FREQUENCY, 50000000, IN_CLOCK frequency in Hz.
- NUM_OF_DATA_BITS_IN_PACK, 8, bits per pack (N).
- RX_MASSIV_DEEP, 4, maximum packs per frame (D ≥ 1).
- IDLE_GAP_BITS, 20, idle bit periods that close a partial frame (≥ 1).
- RX_MASSIV_DEEP_LOG_2, $clog2(RX_MASSIV_DEEP), count width helper.

Ports:
- IN_CLOCK  in  1  single clock; all logic on posedge.
- IN_RESET  in  1  asynchronous, active-high reset.
- IN_PACK_READY  in  1  one-cycle pulse from UART RX, synchronous to IN_CLOCK.
- IN_PACK_DATA  in  N  pack value; valid while IN_PACK_READY=1.
- IN_PACK_ERROR  in  1  parity/stop error for this pack; valid while IN_PACK_READY=1.
- IN_FRAME_ACK  in  1  consumer has taken the frame.
- OUT_FRAME_VALID  out  1  frame complete and stable.
- OUT_FRAME_DATA  out  N*D  pack k at bits [k*N +: N]; slots not received read as 0.
- OUT_FRAME_NUM_PACKS  out  RX_MASSIV_DEEP_LOG_2+1  packs in the current frame (0..D).
- OUT_FRAME_ERROR  out  1  OR of IN_PACK_ERROR over the frame's packs.
- OUT_FRAME_OVERFLOW  out  1  at least one pack was dropped while the frame was held.
- OUT_BUSY  out  1  high while in COLLECT.

## Operation
- Derived values: CLKS_PER_BIT = CLOCK_FREQUENCY/UART_BAUD_RATE, integer truncation. T = CLKS_PER_BIT*IDLE_GAP_BITS. The idle timer is wide enough to hold T-1.
- States: IDLE, COLLECT, HOLD. Reset puts the block in IDLE.
- IDLE, on IN_PACK_READY:
  - Clear all data slots, then write the pack to slot 0.
  - Set count=1, error=IN_PACK_ERROR, overflow=0, timer=0.
  - Go to COLLECT, or directly to HOLD when D==1.
- COLLECT, on IN_PACK_READY:
  - Write the pack to slot[count], then count+1.
  - OR IN_PACK_ERROR into the error flag.
  - Set timer=0.
  - If the new count equals D, go to HOLD.
- COLLECT, without IN_PACK_READY:
  - timer+1.
  - If timer==T-1, go to HOLD (idle close).
- HOLD:
  - OUT_FRAME_VALID=1; data, count and error are frozen.
  - An IN_PACK_READY without IN_FRAME_ACK drops the pack and sets OUT_FRAME_OVERFLOW.
- HOLD, on IN_FRAME_ACK:
  - Clear valid and overflow.
  - Without a pack in the same cycle, go to IDLE. Data and count stay at their last values until the next frame start.
  - With IN_PACK_READY in the same cycle, that pack starts a new frame exactly as in IDLE; it is not dropped.
- IN_FRAME_ACK outside HOLD is ignored.
- Errored packs are stored and counted like good ones.
- OUT_BUSY = (state==COLLECT).

## Timing
- Reset values: all outputs 0, all slots 0, count 0, timer 0. Reset acts immediately, including mid-COLLECT or mid-HOLD; the partial frame is discarded.
- A pack sampled at edge e is visible on OUT_FRAME_DATA and OUT_FRAME_NUM_PACKS after edge e.
- Full close: OUT_FRAME_VALID rises after the same edge e that samples the D-th pack (latency 1 clock from the pulse cycle).
- Idle close: with the last pack sampled at edge e and no further packs, OUT_FRAME_VALID rises after edge e+T.
  - A pack at edge e+T-1 or earlier restarts the timer.
- Valid falls after the edge that samples IN_FRAME_ACK. Minimum HOLD residence is 1 cycle.
- Back-to-back IN_PACK_READY on consecutive cycles is accepted with no loss, except while in HOLD.

## Test plan
Bench parameters: CLOCK_FREQUENCY=50000000, UART_BAUD_RATE=5000000, IDLE_GAP_BITS=20 (T=200), N=8, D=4.

- Reset: assert IN_RESET mid-COLLECT with 2 packs stored -> all outputs 0 asynchronously. After release, the next pack 0x3C gives data 0x0000003C, count 1.
- Full frame: packs 0x11, 0x22, 0x33, 0x44 at 100-cycle spacing -> valid 1 cycle after the 4th pulse, data 0x44332211, count 4, error 0, overflow 0.
- Idle close: packs 0xA5, 0x5A, then silence -> valid exactly 200 cycles after the 0x5A edge, data 0x00005AA5, count 2. A third pack at 199 cycles instead keeps COLLECT and gives count 3.
- Error: 2nd pack carries IN_PACK_ERROR=1 -> OUT_FRAME_ERROR=1 in HOLD, data still stored. After ack, the next frame starts with error 0.
- Overflow/ack race: hold a full frame without ack and send pack 0x77 -> dropped, overflow 1, data unchanged. Then ack in the same cycle as pack 0x99 -> valid 0, overflow 0, data 0x00000099, count 1, busy 1.
- Consecutive pulses: 4 packs on 4 consecutive cycles -> all captured in order, valid after the 4th.
